// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator
//
// Purpose: generates VGA raster timing. It keeps pixel-column and line
// counters and decodes the visible-area flag and the active-low sync pulses.
// It also produces a pixel-rate enable and a once-per-frame start pulse.
// Every output comes straight from a flop.
//
// Ports:
//   clk        - single clock; all state changes on its rising edge
//   reset      - synchronous, active-high; restarts the raster at (0,0)
//   hCounter   - current pixel column, 0..H_TOTAL-1
//   vCounter   - current line, 0..V_TOTAL-1
//   vidOn      - high while (hCounter, vCounter) lies in the visible area
//   hsync_n    - active-low horizontal sync, aligned with the counters
//   vsync_n    - active-low vertical sync, aligned with the counters
//   pixelTick  - high in the last clk cycle of each pixel
//   frameStart - one-cycle pulse when (0,0) is shown with pixelTick high
//
// Configuration macro: VGA_PIXEL_DIV2_EN
//   defined   -> pixelTick toggles every cycle, so each pixel lasts 2 clks
//   undefined -> pixelTick stays at 1 after reset, so each pixel lasts 1 clk
// ---------------------------------------------------------------------------
module vga_sync_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCounter,
  output logic [9:0] vCounter,
  output logic       vidOn,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       pixelTick,
  output logic       frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       tick_next;

  // Counter positions after the coming edge. The registered pixelTick marks
  // the last cycle of a pixel, so the counters move only when it is set.
  always_comb begin
    h_next = hCounter;
    v_next = vCounter;
    if (pixelTick) begin
      if (hCounter == H_LAST) begin
        h_next = '0;
        if (vCounter == V_LAST) begin
          v_next = '0;
        end else begin
          v_next = vCounter + 10'd1;
        end
      end else begin
        h_next = hCounter + 10'd1;
      end
    end
  end

  // The tick comes out of reset low in both builds. As a result, the first
  // pixel (0,0) always lasts two cycles.
`ifdef VGA_PIXEL_DIV2_EN
  assign tick_next = ~pixelTick;
`else
  assign tick_next = 1'b1;
`endif

  // Decode from the next counter values. The registered flags then always
  // describe the counter values shown alongside them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hCounter   <= '0;
      vCounter   <= '0;
      pixelTick  <= 1'b0;
      frameStart <= 1'b0;
      vidOn      <= 1'b1;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
    end else begin
      hCounter   <= h_next;
      vCounter   <= v_next;
      pixelTick  <= tick_next;
      frameStart <= (h_next == '0) && (v_next == '0) && tick_next;
      vidOn      <= (h_next < H_VIS) && (v_next < V_VIS);
      hsync_n    <= !((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST));
      vsync_n    <= !((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST));
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_generator
//
// Purpose: self-checking bench for vga_sync_generator. Two instances are
// driven from the same clock and reset.
//   dut   - default 800x525 timing; used for the line-level boundaries
//   dut_s - tiny 15x13 raster; whole frames fit in a short run
// A behavioural raster model predicts both instances every cycle. The bench
// pushes each prediction to a queue when it drives the reset for an edge.
// After the edge it pops the prediction and compares it with the outputs.
// Dedicated tasks add checks on timing totals and boundaries.
// ---------------------------------------------------------------------------
module tb_vga_sync_generator;

`ifdef VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // Tiny raster used for frame-level checks.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       tick;
    logic       fs;
  } obs_t;

  typedef struct packed {
    int h;
    int v;
    bit tick;
  } mstate_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] d_h, d_v, s_h, s_v;
  logic       d_vid, d_hs, d_vs, d_tick, d_fs;
  logic       s_vid, s_hs, s_vs, s_tick, s_fs;
  obs_t       obs_d, obs_s, exp_d, exp_s;
  obs_t       sb_d[$];
  obs_t       sb_s[$];
  mstate_t    md, ms;
  int         checks = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  vga_sync_generator dut (
    .clk(clk), .reset(reset), .hCounter(d_h), .vCounter(d_v), .vidOn(d_vid),
    .hsync_n(d_hs), .vsync_n(d_vs), .pixelTick(d_tick), .frameStart(d_fs)
  );

  vga_sync_generator #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_s (
    .clk(clk), .reset(reset), .hCounter(s_h), .vCounter(s_v), .vidOn(s_vid),
    .hsync_n(s_hs), .vsync_n(s_vs), .pixelTick(s_tick), .frameStart(s_fs)
  );

  assign obs_d = {d_h, d_v, d_vid, d_hs, d_vs, d_tick, d_fs};
  assign obs_s = {s_h, s_v, s_vid, s_hs, s_vs, s_tick, s_fs};

  // Raster state after one edge. Reset restarts at (0,0) with the tick low;
  // otherwise the position steps at the end of each pixel.
  function automatic mstate_t model_step(mstate_t s, bit rst, int htot, int vtot);
    mstate_t n;
    n = s;
    if (rst) begin
      n.h = 0; n.v = 0; n.tick = 1'b0;
    end else begin
      if (s.tick) begin
        if (s.h == htot - 1) begin
          n.h = 0;
          n.v = (s.v == vtot - 1) ? 0 : s.v + 1;
        end else begin
          n.h = s.h + 1;
        end
      end
      n.tick = (DIV == 2) ? !s.tick : 1'b1;
    end
    return n;
  endfunction

  function automatic obs_t model_out(mstate_t s, int hv, int hf, int hsw,
                                     int vv, int vf, int vsw);
    obs_t o;
    o.h    = 10'(s.h);
    o.v    = 10'(s.v);
    o.vid  = (s.h < hv) && (s.v < vv);
    o.hs   = !((s.h >= hv + hf) && (s.h < hv + hf + hsw));
    o.vs   = !((s.v >= vv + vf) && (s.v < vv + vf + vsw));
    o.tick = s.tick;
    o.fs   = (s.h == 0) && (s.v == 0) && s.tick;
    return o;
  endfunction

  // Drive reset for the next edge, queue the predictions, then wait until
  // just after that edge so the outputs have settled.
  task automatic drive_cycle(input logic rst);
    @(negedge clk);
    reset = rst;
    md = model_step(md, rst, 800, 525);
    ms = model_step(ms, rst, S_HT, S_VT);
    sb_d.push_back(model_out(md, 640, 16, 96, 480, 10, 2));
    sb_s.push_back(model_out(ms, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS));
    @(posedge clk);
    #1;
    exp_d = sb_d.pop_front();
    exp_s = sb_s.pop_front();
  endtask

  task automatic test_reset();
    int fs_count, fs_idx;
    logic [9:0] h_at3;
    fs_count = 0; fs_idx = 0; h_at3 = '0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1);
      checks++;
      if (obs_d !== exp_d) begin fails++; $display("[TB] FAIL reset_sb_d: got %h want %h", obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL reset_sb_s: got %h want %h", obs_s, exp_s); end
    end
    checks++;
    if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL reset_state: got %h want h=0 v=0 vid=1 hs=1 vs=1 tick=0 fs=0", obs_d);
    end
    // Sample index 1 is the state right after the last reset edge.
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0);
      checks++;
      if (obs_d !== exp_d) begin fails++; $display("[TB] FAIL release_sb_d: got %h want %h", obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL release_sb_s: got %h want %h", obs_s, exp_s); end
      if (obs_d.fs) begin fs_count++; fs_idx = k + 1; end
      if (k + 1 == 2 && (obs_d.h !== 10'd0 || obs_d.v !== 10'd0)) begin
        checks++; fails++; $display("[TB] FAIL first_pixel_hold: got h=%0d v=%0d want 0,0", obs_d.h, obs_d.v);
      end
      if (k + 1 == 3) h_at3 = obs_d.h;
    end
    checks++;
    if (fs_count !== 1 || fs_idx !== 2) begin
      fails++; $display("[TB] FAIL release_frame_start: got %0d pulses at cycle %0d want 1 at cycle 2", fs_count, fs_idx);
    end
    checks++;
    if (h_at3 !== 10'd1) begin fails++; $display("[TB] FAIL first_pixel_len: got h=%0d in cycle 3 want 1", h_at3); end
  endtask

  task automatic test_hline();
    obs_t prev;
    int line_len, vid_cnt, hs_cnt;
    bit b_vid, b_hfall, b_hrise;
    line_len = 0; vid_cnt = 0; hs_cnt = 0;
    b_vid = 0; b_hfall = 0; b_hrise = 0;
    prev = obs_d;
    for (int i = 0; i < 3 * 800 * DIV && obs_d.v != 10'd2; i++) begin
      drive_cycle(1'b0);
      checks++;
      if (obs_d !== exp_d) begin fails++; $display("[TB] FAIL hline_sb_d: got %h want %h", obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL hline_sb_s: got %h want %h", obs_s, exp_s); end
      if (obs_d.v == 10'd1) begin
        line_len++;
        if (obs_d.vid) vid_cnt++;
        if (!obs_d.hs) hs_cnt++;
      end
      if (prev.h == 10'd639 && obs_d.h == 10'd640) begin
        b_vid = 1; checks++;
        if (prev.vid !== 1'b1 || obs_d.vid !== 1'b0) begin
          fails++; $display("[TB] FAIL vid_fall_640: got %b->%b want 1->0", prev.vid, obs_d.vid);
        end
      end
      if (prev.h == 10'd655 && obs_d.h == 10'd656) begin
        b_hfall = 1; checks++;
        if (prev.hs !== 1'b1 || obs_d.hs !== 1'b0) begin
          fails++; $display("[TB] FAIL hsync_fall_656: got %b->%b want 1->0", prev.hs, obs_d.hs);
        end
      end
      if (prev.h == 10'd751 && obs_d.h == 10'd752) begin
        b_hrise = 1; checks++;
        if (prev.hs !== 1'b0 || obs_d.hs !== 1'b1) begin
          fails++; $display("[TB] FAIL hsync_rise_752: got %b->%b want 0->1", prev.hs, obs_d.hs);
        end
      end
      prev = obs_d;
    end
    checks++;
    if (!(b_vid && b_hfall && b_hrise)) begin
      fails++; $display("[TB] FAIL h_boundaries_reached: got %b%b%b want 111", b_vid, b_hfall, b_hrise);
    end
    checks++;
    if (line_len !== 800 * DIV) begin fails++; $display("[TB] FAIL line_length: got %0d want %0d", line_len, 800 * DIV); end
    checks++;
    if (vid_cnt !== 640 * DIV) begin fails++; $display("[TB] FAIL line_vid_cycles: got %0d want %0d", vid_cnt, 640 * DIV); end
    checks++;
    if (hs_cnt !== 96 * DIV) begin fails++; $display("[TB] FAIL line_hsync_cycles: got %0d want %0d", hs_cnt, 96 * DIV); end
  endtask

  task automatic test_frame();
    obs_t prev;
    int pulses, period, vid_cnt, vs_cnt, late_vid;
    bit wrap_seen, vfall_seen;
    pulses = 0; period = 0; vid_cnt = 0; vs_cnt = 0; late_vid = 0;
    wrap_seen = 0; vfall_seen = 0;
    prev = obs_s;
    for (int i = 0; i < 4 * S_HT * S_VT * DIV + 10 && pulses < 3; i++) begin
      drive_cycle(1'b0);
      checks++;
      if (obs_d !== exp_d) begin fails++; $display("[TB] FAIL frame_sb_d: got %h want %h", obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL frame_sb_s: got %h want %h", obs_s, exp_s); end
      if (obs_s.fs) begin
        if (pulses > 0) begin
          checks++;
          if (period !== S_HT * S_VT * DIV) begin fails++; $display("[TB] FAIL frame_period: got %0d want %0d", period, S_HT * S_VT * DIV); end
          checks++;
          if (vid_cnt !== S_HV * S_VV * DIV) begin fails++; $display("[TB] FAIL frame_vid_cycles: got %0d want %0d", vid_cnt, S_HV * S_VV * DIV); end
          checks++;
          if (vs_cnt !== S_VS * S_HT * DIV) begin fails++; $display("[TB] FAIL frame_vsync_cycles: got %0d want %0d", vs_cnt, S_VS * S_HT * DIV); end
        end
        pulses++; period = 0; vid_cnt = 0; vs_cnt = 0;
      end
      period++;
      if (obs_s.vid) vid_cnt++;
      if (!obs_s.vs) vs_cnt++;
      if (obs_s.v >= 10'(S_VV) && obs_s.vid) late_vid++;
      if (prev.h == 10'(S_HT - 1) && prev.v == 10'(S_VT - 1) && prev.tick) begin
        wrap_seen = 1; checks++;
        if (obs_s.h !== 10'd0 || obs_s.v !== 10'd0 || obs_s.vid !== 1'b1 || obs_s.fs !== 1'(DIV == 1)) begin
          fails++; $display("[TB] FAIL wrap: got h=%0d v=%0d vid=%b fs=%b want 0 0 1 %0d",
                            obs_s.h, obs_s.v, obs_s.vid, obs_s.fs, DIV == 1);
        end
      end
      if (prev.v == 10'(S_VV + S_VF - 1) && obs_s.v == 10'(S_VV + S_VF)) begin
        vfall_seen = 1; checks++;
        if (prev.vs !== 1'b1 || obs_s.vs !== 1'b0) begin
          fails++; $display("[TB] FAIL vsync_fall: got %b->%b want 1->0", prev.vs, obs_s.vs);
        end
      end
      prev = obs_s;
    end
    checks++;
    if (pulses < 3 || !wrap_seen || !vfall_seen) begin
      fails++; $display("[TB] FAIL frame_events: got pulses=%0d wrap=%b vfall=%b want 3 1 1", pulses, wrap_seen, vfall_seen);
    end
    checks++;
    if (late_vid !== 0) begin fails++; $display("[TB] FAIL blank_lines_vid: got %0d cycles want 0", late_vid); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 900 * DIV && obs_d.h != 10'd700; i++) begin
      drive_cycle(1'b0);
      checks++;
      if (obs_d !== exp_d) begin fails++; $display("[TB] FAIL seek_sb_d: got %h want %h", obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL seek_sb_s: got %h want %h", obs_s, exp_s); end
    end
    checks++;
    if (obs_d.h !== 10'd700 || obs_d.v == 10'd0) begin
      fails++; $display("[TB] FAIL mid_reset_seek: got h=%0d v=%0d want 700 with v>0", obs_d.h, obs_d.v);
    end
    drive_cycle(1'b1);
    checks++;
    if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL mid_reset_state: got %h want h=0 v=0 vid=1 hs=1 vs=1 tick=0 fs=0", obs_d);
    end
    checks++;
    if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL mid_reset_sb_s: got %h want %h", obs_s, exp_s); end
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0);
      checks++;
      if (obs_d !== exp_d) begin fails++; $display("[TB] FAIL restart_sb_d: got %h want %h", obs_d, exp_d); end
      checks++;
      if (obs_s !== exp_s) begin fails++; $display("[TB] FAIL restart_sb_s: got %h want %h", obs_s, exp_s); end
      if (k == 0) begin
        checks++;
        if (obs_d.h !== 10'd0 || obs_d.fs !== 1'b1) begin
          fails++; $display("[TB] FAIL restart_pulse: got h=%0d fs=%b want 0 1", obs_d.h, obs_d.fs);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] vga_sync_generator bench, pixel divider %0d", DIV);
    test_reset();
    test_hline();
    test_frame();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
